// File: rtl/pixel_state_controller.sv
// pixel_state_controller
// Sequences one pixel-array frame: ERASE -> EXPOSE -> CONVERT -> READ -> IDLE.
// Every output is registered and changes on the rising edge of clk.
// The conversion counter saturates at its maximum and otherwise holds its
// value until the next CONVERT entry clears it.
// Optional build macro PIXEL_CONTINUOUS_CAPTURE_EN: when defined, a finished
// READ goes straight back to ERASE (frame_done still pulses) unless abort is
// high. When undefined, a finished READ returns to IDLE.
module pixel_state_controller #(
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 255,
    parameter int ROWS           = 2,
    parameter int READ_CYCLES    = 2,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    output logic                     power_enable,
    output logic                     erase,
    output logic                     expose,
    output logic                     counter_reset,
    output logic                     write_enable,
    output logic [ROWS-1:0]          read,
    output logic [COUNTER_WIDTH-1:0] counter_value,
    output logic                     busy,
    output logic                     frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ
    } state_t;

    // Terminal values of the per-phase cycle counter.
    localparam logic [31:0] ERASE_LAST   = 32'(ERASE_CYCLES - 1);
    localparam logic [31:0] EXPOSE_LAST  = 32'(EXPOSE_CYCLES - 1);
    localparam logic [31:0] CONVERT_LAST = 32'(CONVERT_CYCLES - 1);
    localparam logic [31:0] READ_LAST    = 32'(READ_CYCLES - 1);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [ROWS-1:0]          ROW_FIRST = ROWS'(1);

    state_t      state_reg;
    logic [31:0] cnt_reg;     // cycles already spent in the current phase / row

    // Frame sequencer: state, phase counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            power_enable  <= 1'b0;
            erase         <= 1'b0;
            expose        <= 1'b0;
            counter_reset <= 1'b0;
            write_enable  <= 1'b0;
            read          <= '0;
            counter_value <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            // Single-cycle pulses fall back low unless re-asserted below.
            frame_done    <= 1'b0;
            counter_reset <= 1'b0;

            if (state_reg == ST_IDLE) begin
                // abort has priority over start while idle.
                if (start && !abort) begin
                    state_reg    <= ST_ERASE;
                    cnt_reg      <= '0;
                    erase        <= 1'b1;
                    power_enable <= 1'b1;
                    busy         <= 1'b1;
                end
            end else if (abort) begin
                // Drop the frame; counter_value is deliberately left as is.
                state_reg    <= ST_IDLE;
                cnt_reg      <= '0;
                power_enable <= 1'b0;
                erase        <= 1'b0;
                expose       <= 1'b0;
                write_enable <= 1'b0;
                read         <= '0;
                busy         <= 1'b0;
            end else begin
                case (state_reg)
                    ST_ERASE: begin
                        if (cnt_reg == ERASE_LAST) begin
                            state_reg <= ST_EXPOSE;
                            cnt_reg   <= '0;
                            erase     <= 1'b0;
                            expose    <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end

                    ST_EXPOSE: begin
                        if (cnt_reg == EXPOSE_LAST) begin
                            // First CONVERT cycle shows a cleared counter.
                            state_reg     <= ST_CONVERT;
                            cnt_reg       <= '0;
                            expose        <= 1'b0;
                            write_enable  <= 1'b1;
                            counter_reset <= 1'b1;
                            counter_value <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end
                    end

                    ST_CONVERT: begin
                        if (cnt_reg == CONVERT_LAST) begin
                            state_reg    <= ST_READ;
                            cnt_reg      <= '0;
                            write_enable <= 1'b0;
                            read         <= ROW_FIRST;
                        end else begin
                            cnt_reg <= cnt_reg + 32'd1;
                            if (counter_value != COUNT_MAX) begin
                                counter_value <= counter_value + 1'b1;
                            end
                        end
                    end

                    ST_READ: begin
                        if (cnt_reg != READ_LAST) begin
                            cnt_reg <= cnt_reg + 32'd1;
                        end else if (!read[ROWS-1]) begin
                            // Walk the one-hot select to the next row.
                            cnt_reg <= '0;
                            read    <= read << 1;
                        end else begin
                            // Last cycle of the last row: the frame is complete.
                            cnt_reg    <= '0;
                            read       <= '0;
                            frame_done <= 1'b1;
`ifdef PIXEL_CONTINUOUS_CAPTURE_EN
                            state_reg  <= ST_ERASE;
                            erase      <= 1'b1;
`else
                            state_reg    <= ST_IDLE;
                            power_enable <= 1'b0;
                            busy         <= 1'b0;
`endif
                        end
                    end

                    default: begin
                        state_reg    <= ST_IDLE;
                        cnt_reg      <= '0;
                        power_enable <= 1'b0;
                        erase        <= 1'b0;
                        expose       <= 1'b0;
                        write_enable <= 1'b0;
                        read         <= '0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_state_controller.sv
// Directed testbench for pixel_state_controller (default build, no continuous
// capture). Cycle N is the clock period following the N-th rising edge after
// start is presented; outputs are sampled on the falling edge.
module tb_pixel_state_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       start2;

    // Nominal instance: ERASE 3, EXPOSE 4, CONVERT 6, ROWS 2, READ 2, width 8.
    logic       power_enable, erase, expose, counter_reset, write_enable;
    logic [1:0] read;
    logic [7:0] counter_value;
    logic       busy, frame_done;

    // Saturation instance: CONVERT 12, width 3.
    logic       power_enable2, erase2, expose2, counter_reset2, write_enable2;
    logic [1:0] read2;
    logic [2:0] counter_value2;
    logic       busy2, frame_done2;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_hold = 8'd0;   // counter value expected to be held outside CONVERT

    logic [8:0] obs;
    assign obs = {power_enable, erase, expose, counter_reset, write_enable,
                  read, frame_done, busy};

    pixel_state_controller #(
        .ERASE_CYCLES(3), .EXPOSE_CYCLES(4), .CONVERT_CYCLES(6),
        .ROWS(2), .READ_CYCLES(2), .COUNTER_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .power_enable(power_enable), .erase(erase), .expose(expose),
        .counter_reset(counter_reset), .write_enable(write_enable),
        .read(read), .counter_value(counter_value), .busy(busy),
        .frame_done(frame_done)
    );

    pixel_state_controller #(
        .ERASE_CYCLES(3), .EXPOSE_CYCLES(4), .CONVERT_CYCLES(12),
        .ROWS(2), .READ_CYCLES(2), .COUNTER_WIDTH(3)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0),
        .power_enable(power_enable2), .erase(erase2), .expose(expose2),
        .counter_reset(counter_reset2), .write_enable(write_enable2),
        .read(read2), .counter_value(counter_value2), .busy(busy2),
        .frame_done(frame_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [8:0] e;
        #1 reset = 1'b0;
        #1;
        e = 9'b0;
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b expected %b", obs, e);
        end
        compared++;
        if (counter_value !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_counter: got %0d expected 0", counter_value);
        end
        repeat (2) @(negedge clk);
        compared++;
        if (obs !== e || busy2 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_held: got %b busy2 %b expected %b", obs, busy2, e);
        end
        reset = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    // Full frame checked cycle by cycle; optionally pokes start during EXPOSE.
    task automatic test_nominal(input bit poke_start);
        logic [8:0] e;
        logic [7:0] ec;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            start = (poke_start && c == 5);
            e = 9'b0;
            if (c >= 1 && c <= 17) begin e[8] = 1'b1; e[0] = 1'b1; end
            if (c >= 1 && c <= 3)   e[7] = 1'b1;
            if (c >= 4 && c <= 7)   e[6] = 1'b1;
            if (c == 8)             e[5] = 1'b1;
            if (c >= 8 && c <= 13)  e[4] = 1'b1;
            if (c >= 14 && c <= 15) e[3:2] = 2'b01;
            if (c >= 16 && c <= 17) e[3:2] = 2'b10;
            if (c == 18)            e[1] = 1'b1;
            if (c < 8)       ec = exp_hold;
            else if (c <= 13) ec = 8'(c - 8);
            else             ec = 8'd5;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL nominal_outputs cycle %0d: got %b expected %b", c, obs, e);
            end
            compared++;
            if (counter_value !== ec) begin
                mismatched++;
                $display("FAIL nominal_counter cycle %0d: got %0d expected %0d", c, counter_value, ec);
            end
        end
        exp_hold = 8'd5;
        $display("test_nominal poke_start=%0d done", poke_start);
    endtask

    task automatic test_abort();
        logic [8:0] e;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 3)      e = 9'b1_1_0_0_0_00_0_1;
            else if (c <= 5) e = 9'b1_0_1_0_0_00_0_1;
            else             e = 9'b0;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL abort_outputs cycle %0d: got %b expected %b", c, obs, e);
            end
            if (c >= 6) begin
                compared++;
                if (counter_value !== exp_hold) begin
                    mismatched++;
                    $display("FAIL abort_counter cycle %0d: got %0d expected %0d", c, counter_value, exp_hold);
                end
            end
            abort = (c == 5);
        end
        $display("test_abort done");
        // Clean frame with start presented in cycle 10.
        test_nominal(1'b0);
    endtask

    task automatic test_idle_start_abort();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            compared++;
            if (busy !== 1'b0 || erase !== 1'b0) begin
                mismatched++;
                $display("FAIL idle_start_abort cycle %0d: got busy %b erase %b expected 0 0", c, busy, erase);
            end
        end
        $display("test_idle_start_abort done");
    endtask

    task automatic test_saturation();
        logic [2:0] ec;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c < 8)       ec = 3'd0;
            else if (c < 15) ec = 3'(c - 8);
            else             ec = 3'd7;
            compared++;
            if (counter_value2 !== ec) begin
                mismatched++;
                $display("FAIL saturation_counter cycle %0d: got %0d expected %0d", c, counter_value2, ec);
            end
            if (c == 19 || c == 20 || c == 24 || c == 25) begin
                compared++;
                if (write_enable2 !== (c == 19) || frame_done2 !== (c == 24)) begin
                    mismatched++;
                    $display("FAIL saturation_timing cycle %0d: got we %b fd %b expected %b %b",
                             c, write_enable2, frame_done2, (c == 19), (c == 24));
                end
            end
        end
        $display("test_saturation done");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        compared++;
        if (write_enable !== 1'b1 || counter_value !== 8'd2) begin
            mismatched++;
            $display("FAIL async_pre_convert: got we %b cnt %0d expected 1 2", write_enable, counter_value);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (obs !== 9'b0 || counter_value !== 8'd0) begin
            mismatched++;
            $display("FAIL async_reset_outputs: got %b cnt %0d expected 0 0", obs, counter_value);
        end
        exp_hold = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            compared++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL async_after_release cycle %0d: got fd %b busy %b expected 0 0", c, frame_done, busy);
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_start_after_reset();
        @(negedge clk);
        reset = 1'b0;
        #1 reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (erase !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL start_after_reset: got erase %b busy %b expected 1 1", erase, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0 || erase !== 1'b0 || frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_in_erase: got busy %b erase %b fd %b expected 0 0 0", busy, erase, frame_done);
        end
        $display("test_start_after_reset done");
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_nominal(1'b0);
        test_abort();
        test_idle_start_abort();
        test_nominal(1'b1);
        test_saturation();
        test_async_reset();
        test_start_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
